// File: rtl/change_pkg.sv
// Shared coin codes, collector states and payment limits for the vending front end.
package change_pkg;

  typedef enum logic [1:0] {
    COIN_NONE     = 2'b00,
    COIN_CIRCLE   = 2'b01,
    COIN_TRIANGLE = 2'b10,
    COIN_PENTAGON = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    REFUND  = 2'd3
  } collector_state_t;

  // Largest payment that fits the 4-bit Paid register.
  localparam logic [4:0] MAX_PAID = 5'd15;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_CIRCLE:   return 4'd1;
      COIN_TRIANGLE: return 4'd3;
      COIN_PENTAGON: return 4'd5;
      default:       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three saturating 2-bit coin counts with per-type increment, decrement (0..2) and full flags.
module coin_inventory #(
  parameter int unsigned INIT_PENT = 2,
  parameter int unsigned INIT_TRI  = 2,
  parameter int unsigned INIT_CIRC = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc_pent,
  input  logic       i_inc_tri,
  input  logic       i_inc_circ,
  input  logic [1:0] i_dec_pent,
  input  logic [1:0] i_dec_tri,
  input  logic [1:0] i_dec_circ,
  output logic [1:0] o_pent,
  output logic [1:0] o_tri,
  output logic [1:0] o_circ,
  output logic       o_full_pent,
  output logic       o_full_tri,
  output logic       o_full_circ
);

  localparam logic [1:0] P_INIT = 2'(INIT_PENT);
  localparam logic [1:0] T_INIT = 2'(INIT_TRI);
  localparam logic [1:0] C_INIT = 2'(INIT_CIRC);

  logic [1:0] r_pent;
  logic [1:0] r_tri;
  logic [1:0] r_circ;

  // Apply the increment first, then the decrement, clamping to 0..3.
  function automatic logic [1:0] f_next(input logic [1:0] cnt, input logic inc,
                                        input logic [1:0] dec);
    logic [2:0] up;
    logic [2:0] dn;
    up = {1'b0, cnt} + {2'b00, inc};
    dn = {1'b0, dec};
    if (dn >= up) begin
      return 2'd0;
    end else if ((up - dn) > 3'd3) begin
      return 2'd3;
    end else begin
      return 2'(up - dn);
    end
  endfunction

  // Inventory count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pent <= P_INIT;
      r_tri  <= T_INIT;
      r_circ <= C_INIT;
    end else begin
      r_pent <= f_next(r_pent, i_inc_pent, i_dec_pent);
      r_tri  <= f_next(r_tri,  i_inc_tri,  i_dec_tri);
      r_circ <= f_next(r_circ, i_inc_circ, i_dec_circ);
    end
  end

  assign o_pent      = r_pent;
  assign o_tri       = r_tri;
  assign o_circ      = r_circ;
  assign o_full_pent = (r_pent == 2'd3);
  assign o_full_tri  = (r_tri  == 2'd3);
  assign o_full_circ = (r_circ == 2'd3);

endmodule

// File: rtl/coin_collector.sv
// Vending front end: latches a cost, collects coins, hands the transaction to the
// change maker and refunds the inserted coins on cancel.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting coins until Paid >= Cost or cancel
// PRESENT | Cost/Paid/inventory offered to the change maker
// REFUND  | returning this transaction's coins, pentagons first
module coin_collector
  import change_pkg::*;
#(
  parameter int unsigned INIT_PENT = 2,
  parameter int unsigned INIT_TRI  = 2,
  parameter int unsigned INIT_CIRC = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic [3:0] cost_in,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  output logic       coin_ready,
  output logic       coin_reject,
  input  logic       cancel,
  output logic       txn_valid,
  input  logic       txn_ready,
  input  logic [1:0] disp_first,
  input  logic [1:0] disp_second,
  output logic [3:0] Cost,
  output logic [3:0] Paid,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic       refund_valid,
  output logic [1:0] refund_type,
  input  logic       refund_ready,
  output logic       busy
);

  collector_state_t r_state;
  collector_state_t w_next;

  logic [3:0] r_cost;
  logic [3:0] r_paid;
  logic [1:0] r_ins_p;
  logic [1:0] r_ins_t;
  logic [1:0] r_ins_c;
  logic       r_reject;
  logic       r_refund_valid;
  logic [1:0] r_refund_type;

  logic [1:0] w_pent;
  logic [1:0] w_tri;
  logic [1:0] w_circ;
  logic       w_full_p;
  logic       w_full_t;
  logic       w_full_c;

  logic       w_coin_xfer;
  logic [3:0] w_value;
  logic [4:0] w_sum;
  logic       w_type_full;
  logic       w_reject;
  logic       w_accept;
  logic       w_txn_hs;
  logic       w_ref_hs;
  logic       w_ins_any;
  logic [1:0] w_ref_pick;
  logic [3:0] w_ref_value;
  logic       w_inc_p;
  logic       w_inc_t;
  logic       w_inc_c;
  logic [1:0] w_dec_p;
  logic [1:0] w_dec_t;
  logic [1:0] w_dec_c;

  assign w_coin_xfer = (r_state == COLLECT) && coin_valid && (coin_type != COIN_NONE);
  assign w_value     = coin_value(coin_type);
  assign w_sum       = {1'b0, r_paid} + {1'b0, w_value};
  assign w_reject    = w_coin_xfer && ((w_sum > MAX_PAID) || w_type_full);
  assign w_accept    = w_coin_xfer && !((w_sum > MAX_PAID) || w_type_full);
  assign w_txn_hs    = (r_state == PRESENT) && txn_ready;
  assign w_ref_hs    = (r_state == REFUND) && r_refund_valid && refund_ready;
  assign w_ins_any   = (r_ins_p != 2'd0) || (r_ins_t != 2'd0) || (r_ins_c != 2'd0);
  assign w_ref_value = coin_value(r_refund_type);

  assign w_inc_p = w_accept && (coin_type == COIN_PENTAGON);
  assign w_inc_t = w_accept && (coin_type == COIN_TRIANGLE);
  assign w_inc_c = w_accept && (coin_type == COIN_CIRCLE);

  // Full flag for the type of the coin being presented.
  always_comb begin
    w_type_full = 1'b0;
    case (coin_type)
      COIN_PENTAGON: w_type_full = w_full_p;
      COIN_TRIANGLE: w_type_full = w_full_t;
      COIN_CIRCLE:   w_type_full = w_full_c;
      default:       w_type_full = 1'b0;
    endcase
  end

  // Next refund coin: pentagons, then triangles, then circles.
  always_comb begin
    w_ref_pick = COIN_CIRCLE;
    if (r_ins_p != 2'd0) begin
      w_ref_pick = COIN_PENTAGON;
    end else if (r_ins_t != 2'd0) begin
      w_ref_pick = COIN_TRIANGLE;
    end
  end

  // Inventory decrements from dispensed coins or from a taken refund coin.
  always_comb begin
    w_dec_p = 2'd0;
    w_dec_t = 2'd0;
    w_dec_c = 2'd0;
    if (w_txn_hs) begin
      w_dec_p = {1'b0, disp_first == COIN_PENTAGON} + {1'b0, disp_second == COIN_PENTAGON};
      w_dec_t = {1'b0, disp_first == COIN_TRIANGLE} + {1'b0, disp_second == COIN_TRIANGLE};
      w_dec_c = {1'b0, disp_first == COIN_CIRCLE}   + {1'b0, disp_second == COIN_CIRCLE};
    end else if (w_ref_hs) begin
      w_dec_p = {1'b0, r_refund_type == COIN_PENTAGON};
      w_dec_t = {1'b0, r_refund_type == COIN_TRIANGLE};
      w_dec_c = {1'b0, r_refund_type == COIN_CIRCLE};
    end
  end

  // Next-state decode; cancel wins over a payment-complete coin.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (cost_in == 4'd0) ? PRESENT : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          w_next = REFUND;
        end else if (w_accept && (w_sum[3:0] >= r_cost)) begin
          w_next = PRESENT;
        end
      end
      PRESENT: begin
        if (txn_ready) begin
          w_next = IDLE;
        end
      end
      REFUND: begin
        if (!r_refund_valid && !w_ins_any) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Cost, Paid, per-transaction insert counts, reject pulse and refund offer.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_cost         <= 4'd0;
      r_paid         <= 4'd0;
      r_ins_p        <= 2'd0;
      r_ins_t        <= 2'd0;
      r_ins_c        <= 2'd0;
      r_reject       <= 1'b0;
      r_refund_valid <= 1'b0;
      r_refund_type  <= 2'd0;
    end else begin
      r_reject <= w_reject;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cost  <= cost_in;
            r_paid  <= 4'd0;
            r_ins_p <= 2'd0;
            r_ins_t <= 2'd0;
            r_ins_c <= 2'd0;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_paid <= w_sum[3:0];
            if (w_inc_p) r_ins_p <= r_ins_p + 2'd1;
            if (w_inc_t) r_ins_t <= r_ins_t + 2'd1;
            if (w_inc_c) r_ins_c <= r_ins_c + 2'd1;
          end
        end
        PRESENT: begin
          if (txn_ready) begin
            r_paid <= 4'd0;
          end
        end
        REFUND: begin
          if (w_ref_hs) begin
            r_refund_valid <= 1'b0;
            r_paid         <= r_paid - w_ref_value;
            if (r_refund_type == COIN_PENTAGON) r_ins_p <= r_ins_p - 2'd1;
            if (r_refund_type == COIN_TRIANGLE) r_ins_t <= r_ins_t - 2'd1;
            if (r_refund_type == COIN_CIRCLE)   r_ins_c <= r_ins_c - 2'd1;
          end else if (!r_refund_valid && w_ins_any) begin
            r_refund_valid <= 1'b1;
            r_refund_type  <= w_ref_pick;
          end
        end
        default: ;
      endcase
    end
  end

  coin_inventory #(
    .INIT_PENT (INIT_PENT),
    .INIT_TRI  (INIT_TRI),
    .INIT_CIRC (INIT_CIRC)
  ) u_inventory (
    .i_clk       (clock),
    .i_rst_n     (reset_L),
    .i_inc_pent  (w_inc_p),
    .i_inc_tri   (w_inc_t),
    .i_inc_circ  (w_inc_c),
    .i_dec_pent  (w_dec_p),
    .i_dec_tri   (w_dec_t),
    .i_dec_circ  (w_dec_c),
    .o_pent      (w_pent),
    .o_tri       (w_tri),
    .o_circ      (w_circ),
    .o_full_pent (w_full_p),
    .o_full_tri  (w_full_t),
    .o_full_circ (w_full_c)
  );

  // Refunding every inserted coin must bring Paid back to zero.
  a_refund_paid_zero: assert property (@(posedge clock) disable iff (!reset_L)
    ((r_state == REFUND) && (w_next == IDLE)) |-> (r_paid == 4'd0));

  assign coin_ready   = (r_state == COLLECT);
  assign coin_reject  = r_reject;
  assign txn_valid    = (r_state == PRESENT);
  assign busy         = (r_state != IDLE);
  assign Cost         = r_cost;
  assign Paid         = r_paid;
  assign Pentagons    = w_pent;
  assign Triangles    = w_tri;
  assign Circles      = w_circ;
  assign refund_valid = r_refund_valid;
  assign refund_type  = r_refund_type;

endmodule
